// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: valid/ready request in, one WB cycle out, one-cycle response pulse.
// Optional bus timeout abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_bridge #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_data_o,
  input  logic [DW-1:0]   wb_data_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_stb_o,
  output logic            wb_cyc_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          wb_we_q, wb_we_d;
  logic [SW-1:0] wb_sel_q, wb_sel_d;
  logic          wb_stb_q, wb_stb_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          timeout_c;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW      = (CNT_LOG < 8) ? 8 : ((CNT_LOG > 16) ? 16 : CNT_LOG);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter holds zero outside BUS, so it is cleared on every entry into BUS
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_BUS) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  assign timeout_c = (state_q == ST_BUS) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_sel_d    = wb_sel_q;
    wb_stb_d    = wb_stb_q;
    wb_cyc_d    = wb_cyc_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i) begin
          wb_addr_d   = req_addr_i;
          wb_data_d   = req_wdata_i;
          wb_sel_d    = req_sel_i;
          wb_we_d     = req_we_i;
          wb_cyc_d    = 1'b1;
          wb_stb_d    = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_BUS;
        end
      end
      ST_BUS: begin
        // Error beats ack; both beat timeout
        if (wb_err_i || (!wb_ack_i && timeout_c)) begin
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (wb_ack_i) begin
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          wb_we_d     = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wb_we_q ? '0 : wb_data_i;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        wb_cyc_d    = 1'b0;
        wb_stb_d    = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_sel_q    <= '0;
      wb_stb_q    <= 1'b0;
      wb_cyc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_sel_q    <= wb_sel_d;
      wb_stb_q    <= wb_stb_d;
      wb_cyc_q    <= wb_cyc_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign wb_we_o     = wb_we_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_cyc_o    = wb_cyc_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: transaction-timing reference model checked every cycle, plus directed literal checks.
// With WB_MASTER_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
module tb_wb_master_bridge;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  wb_master_bridge #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES((TMO == 0) ? 255 : TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction start/finish edges and the values each must present
  int          t, start, next_free;
  bit          active, cur_we;
  logic        e_ready, e_rvalid, e_err, e_cyc, e_we;
  logic [31:0] e_rdata, e_addr, e_data;
  logic [3:0]  e_sel;

  task automatic finish_txn(input logic err, input logic [31:0] rdata);
    active    = 0;
    e_cyc     = 0;
    e_rvalid  = 1;
    e_err     = err;
    e_rdata   = rdata;
    next_free = t + 2;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = 0; next_free = 0; active = 0; start = 0; cur_we = 0;
      e_ready = 1; e_rvalid = 0; e_err = 0; e_cyc = 0; e_we = 0;
      e_rdata = '0; e_addr = '0; e_data = '0; e_sel = '0;
    end else begin
      t++;
      e_rvalid = 0;
      if (active) begin
        if (wb_err_i) finish_txn(1'b1, 32'h0);
        else if (wb_ack_i) begin
          finish_txn(1'b0, cur_we ? 32'h0 : wb_data_i);
          e_we = 0;
        end else if (TMO != 0 && (t - start) == TMO) finish_txn(1'b1, 32'h0);
      end else if (t >= next_free && req_valid_i) begin
        active = 1; start = t; cur_we = req_we_i;
        e_addr = req_addr_i; e_data = req_wdata_i; e_sel = req_sel_i; e_we = req_we_i;
        e_cyc = 1;
      end
      e_ready = !active && (t + 1 >= next_free);
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 32'(req_ready_o), 32'(e_ready));
      cmp("rsp_valid", 32'(rsp_valid_o), 32'(e_rvalid));
      cmp("rsp_err", 32'(rsp_err_o), 32'(e_err));
      cmp("rsp_rdata", rsp_rdata_o, e_rdata);
      cmp("wb_cyc", 32'(wb_cyc_o), 32'(e_cyc));
      cmp("wb_stb", 32'(wb_stb_o), 32'(e_cyc));
      cmp("wb_we", 32'(wb_we_o), 32'(e_we));
      cmp("wb_addr", wb_addr_o, e_addr);
      cmp("wb_data", wb_data_o, e_data);
      cmp("wb_sel", 32'(wb_sel_o), 32'(e_sel));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_sel_i = s;
  endtask

  initial begin
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_data_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #12;
    cmp("rst_ready", 32'(req_ready_o), 32'h1);
    cmp("rst_cyc", 32'(wb_cyc_o), 32'h0);
    cmp("rst_rdata", rsp_rdata_o, 32'h0);
    cmp("rst_addr", wb_addr_o, 32'h0);
    chk_en = 1;
    nxt();
    rst = 1'b1;
    nxt();

    // Read with zero-wait ack
    drive_req(1'b1, 1'b0, 32'h1000_0100, 32'hDEAD_BEEF, 4'hF);
    nxt();
    cmp("t1_cyc_up", 32'(wb_cyc_o), 32'h1);
    cmp("t1_ready_low", 32'(req_ready_o), 32'h0);
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1; wb_data_i = 32'hA5A5_0001;
    nxt();
    cmp("t1_cyc_down", 32'(wb_cyc_o), 32'h0);
    cmp("t1_rsp_valid", 32'(rsp_valid_o), 32'h1);
    cmp("t1_rdata", rsp_rdata_o, 32'hA5A5_0001);
    cmp("t1_err", 32'(rsp_err_o), 32'h0);
    wb_ack_i = 1'b0;
    nxt();
    cmp("t1_valid_pulse", 32'(rsp_valid_o), 32'h0);
    cmp("t1_ready_back", 32'(req_ready_o), 32'h1);

    // Write with 3 wait states
    drive_req(1'b1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    wb_data_i = 32'hFFFF_FFFF;
    nxt();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cmp("t2_cyc", 32'(wb_cyc_o), 32'h1);
      cmp("t2_we", 32'(wb_we_o), 32'h1);
      cmp("t2_addr", wb_addr_o, 32'h3000_0004);
      cmp("t2_data", wb_data_o, 32'h1234_5678);
      cmp("t2_sel", 32'(wb_sel_o), 32'hF);
      if (i == 3) wb_ack_i = 1'b1;
      nxt();
    end
    cmp("t2_rsp_valid", 32'(rsp_valid_o), 32'h1);
    cmp("t2_rdata", rsp_rdata_o, 32'h0);
    cmp("t2_err", 32'(rsp_err_o), 32'h0);
    wb_ack_i = 1'b0;
    nxt();

    // Ack and error on the same edge
    drive_req(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'h3);
    nxt();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_data_i = 32'h5555_AAAA;
    nxt();
    cmp("t3_rsp_valid", 32'(rsp_valid_o), 32'h1);
    cmp("t3_err", 32'(rsp_err_o), 32'h1);
    cmp("t3_rdata", rsp_rdata_o, 32'h0);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    nxt();

    // Back-to-back with req_valid held and a stray ack outside BUS
    drive_req(1'b1, 1'b0, 32'h4000_0010, 32'h0, 4'hF);
    nxt();
    cmp("t4_cyc1", 32'(wb_cyc_o), 32'h1);
    wb_ack_i = 1'b1; wb_data_i = 32'h0000_1111;
    nxt();
    cmp("t4_ack1_cyc", 32'(wb_cyc_o), 32'h0);
    cmp("t4_ack1_ready", 32'(req_ready_o), 32'h0);
    wb_data_i = 32'h0000_2222;
    nxt();
    cmp("t4_gap_cyc", 32'(wb_cyc_o), 32'h0);
    cmp("t4_gap_ready", 32'(req_ready_o), 32'h1);
    nxt();
    cmp("t4_cyc2", 32'(wb_cyc_o), 32'h1);
    cmp("t4_cyc2_novalid", 32'(rsp_valid_o), 32'h0);
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nxt();
    cmp("t4_rdata2", rsp_rdata_o, 32'h0000_2222);
    wb_ack_i = 1'b0;
    nxt();

    // Reset while cycle is open
    drive_req(1'b1, 1'b1, 32'h5000_0000, 32'h0BAD_F00D, 4'h1);
    nxt();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cmp("t5_cyc_before", 32'(wb_cyc_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    cmp("t5_cyc_rst", 32'(wb_cyc_o), 32'h0);
    cmp("t5_stb_rst", 32'(wb_stb_o), 32'h0);
    cmp("t5_valid_rst", 32'(rsp_valid_o), 32'h0);
    nxt();
    rst = 1'b1; wb_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      cmp("t5_no_rsp", 32'(rsp_valid_o), 32'h0);
    end
    wb_ack_i = 1'b0;
    nxt();

    // Slave never answers
    drive_req(1'b1, 1'b0, 32'h6000_0000, 32'h0, 4'hF);
    nxt();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (TMO != 0) begin
      for (int i = 1; i < TMO; i++) begin
        nxt();
        cmp("t6_cyc_wait", 32'(wb_cyc_o), 32'h1);
      end
      nxt();
      cmp("t6_cyc_drop", 32'(wb_cyc_o), 32'h0);
      cmp("t6_err", 32'(rsp_err_o), 32'h1);
      cmp("t6_rdata", rsp_rdata_o, 32'h0);
    end else begin
      for (int i = 0; i < 1000; i++) nxt();
      cmp("t6_cyc_held", 32'(wb_cyc_o), 32'h1);
      wb_ack_i = 1'b1;
      nxt();
      wb_ack_i = 1'b0;
    end
    nxt();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                4'($urandom));
      wb_data_i = $urandom;
      wb_ack_i  = ($urandom % 3) == 0;
      wb_err_i  = ($urandom % 8) == 0;
      nxt();
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1; wb_err_i = 1'b0;
    nxt();
    wb_ack_i = 1'b0;
    nxt();
    nxt();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
